// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry result buffers for ALU, LSB and BRU feeding a registered CDB.
// Optional macro CDB_LSB_PRIORITY_EN: a full LSB buffer always wins; ALU/BRU share a 1-bit round-robin.
module cdb_arbiter #(
  parameter int ROB_IDX_W = 6,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 alu_valid,
  input  logic [ROB_IDX_W-1:0] alu_rob_index,
  input  logic [DATA_W-1:0]    alu_value,
  output logic                 alu_ready,
  input  logic                 lsb_valid,
  input  logic [ROB_IDX_W-1:0] lsb_rob_index,
  input  logic [DATA_W-1:0]    lsb_value,
  output logic                 lsb_ready,
  input  logic                 bru_valid,
  input  logic [ROB_IDX_W-1:0] bru_rob_index,
  input  logic [DATA_W-1:0]    bru_value,
  output logic                 bru_ready,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_rob_index,
  output logic [DATA_W-1:0]    cdb_value,
  output logic [1:0]           cdb_src,
  output logic                 busy
);

  localparam int NSRC = 3;

  logic [NSRC-1:0]      in_valid_s;
  logic [ROB_IDX_W-1:0] in_tag_s [NSRC];
  logic [DATA_W-1:0]    in_val_s [NSRC];

  logic [NSRC-1:0]      full_q, full_d;
  logic [ROB_IDX_W-1:0] tag_q [NSRC];
  logic [ROB_IDX_W-1:0] tag_d [NSRC];
  logic [DATA_W-1:0]    val_q [NSRC];
  logic [DATA_W-1:0]    val_d [NSRC];

`ifdef CDB_LSB_PRIORITY_EN
  logic                 ptr_q, ptr_d;
`else
  logic [1:0]           ptr_q, ptr_d;
`endif

  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]    cdb_val_q, cdb_val_d;
  logic [1:0]           cdb_src_q, cdb_src_d;

  logic [NSRC-1:0]      grant_s;
  logic [NSRC-1:0]      ready_s;
  logic [NSRC-1:0]      accept_s;
  logic [1:0]           win_s;
  logic                 any_full_s;

  assign in_valid_s  = {bru_valid, lsb_valid, alu_valid};
  assign in_tag_s[0] = alu_rob_index;
  assign in_tag_s[1] = lsb_rob_index;
  assign in_tag_s[2] = bru_rob_index;
  assign in_val_s[0] = alu_value;
  assign in_val_s[1] = lsb_value;
  assign in_val_s[2] = bru_value;

`ifndef CDB_LSB_PRIORITY_EN
  // First full buffer found when scanning start, start+1, start+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] full, input logic [1:0] start);
    logic [2:0] sum;
    logic [2:0] idx;
    logic       found;
    logic [1:0] pick;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, start} + 3'(k);
      idx = (sum >= 3'd3) ? (sum - 3'd3) : sum;
      if (full[idx[1:0]] && !found) begin
        pick  = idx[1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction
`endif

  // Winner selection from the full flags and the round-robin pointer.
  always_comb begin
    win_s = 2'd0;
`ifdef CDB_LSB_PRIORITY_EN
    if (full_q[1]) begin
      win_s = 2'd1;
    end else if (full_q[0] && full_q[2]) begin
      win_s = ptr_q ? 2'd2 : 2'd0;
    end else if (full_q[2]) begin
      win_s = 2'd2;
    end else begin
      win_s = 2'd0;
    end
`else
    win_s = rr_pick(full_q, ptr_q);
`endif
  end

  assign any_full_s = |full_q;
  assign grant_s    = any_full_s ? (3'b001 << win_s) : 3'b000;
  // A granted buffer frees up at the edge, so it may accept new data in the same cycle.
  assign ready_s    = {NSRC{rst & rdy & ~flush}} & (~full_q | grant_s);
  assign accept_s   = in_valid_s & ready_s;

  // Next-state: flush beats everything, rdy low freezes, otherwise load/drain/broadcast.
  always_comb begin
    full_d      = full_q;
    tag_d       = tag_q;
    val_d       = val_q;
    ptr_d       = ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_val_d   = cdb_val_q;
    cdb_src_d   = cdb_src_q;
    if (rdy && flush) begin
      full_d      = '0;
      cdb_valid_d = 1'b0;
      ptr_d       = '0;
    end else if (rdy) begin
      for (int i = 0; i < NSRC; i++) begin
        if (accept_s[i]) begin
          full_d[i] = 1'b1;
          tag_d[i]  = in_tag_s[i];
          val_d[i]  = in_val_s[i];
        end else if (grant_s[i]) begin
          full_d[i] = 1'b0;
        end else begin
          full_d[i] = full_q[i];
        end
      end
      cdb_valid_d = any_full_s;
      if (any_full_s) begin
        cdb_tag_d = tag_q[win_s];
        cdb_val_d = val_q[win_s];
        cdb_src_d = win_s;
`ifdef CDB_LSB_PRIORITY_EN
        case (win_s)
          2'd0:    ptr_d = 1'b1;
          2'd2:    ptr_d = 1'b0;
          default: ptr_d = ptr_q;
        endcase
`else
        ptr_d = (win_s == 2'd2) ? 2'd0 : (win_s + 2'd1);
`endif
      end else begin
        cdb_src_d = cdb_src_q;
      end
    end else begin
      full_d = full_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= '0;
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_val_q   <= '0;
      cdb_src_q   <= 2'd0;
      for (int i = 0; i < NSRC; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      full_q      <= full_d;
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_val_q   <= cdb_val_d;
      cdb_src_q   <= cdb_src_d;
      tag_q       <= tag_d;
      val_q       <= val_d;
    end
  end

  assign alu_ready     = ready_s[0];
  assign lsb_ready     = ready_s[1];
  assign bru_ready     = ready_s[2];
  assign cdb_valid     = cdb_valid_q;
  assign cdb_rob_index = cdb_tag_q;
  assign cdb_value     = cdb_val_q;
  assign cdb_src       = cdb_src_q;
  assign busy          = any_full_s;

endmodule
